// File: rtl/priority_encoder_32x5.sv
// Registered 32-to-5 priority encoder: sticky pending requests, masked highest-index
// grant held in eout/valid until the consumer acks it.
module priority_encoder_32x5 #(
  parameter int N = 32,
  parameter int W = 5
) (
  input  logic         clk,
  input  logic         clr,
  input  logic [N-1:0] req,
  input  logic         ld,
  input  logic [N-1:0] mask,
  input  logic         ack,
  output logic [W-1:0] eout,
  output logic         valid,
  output logic [N-1:0] pending
);

  typedef enum logic [0:0] {
    IDLE    = 1'b0,
    PRESENT = 1'b1
  } state_t;

  state_t         state_r, state_next_s;
  logic [W-1:0]   eout_r, eout_next_s;
  logic           valid_r, valid_next_s;
  logic [N-1:0]   pending_r, pending_next_s;
  logic [N-1:0]   eligible_s;
  logic [N-1:0]   clr_vec_s;
  logic [W-1:0]   enc_s;
  logic           found_s;

  // Later iterations overwrite earlier ones, so the highest set index wins.
  function automatic logic [W-1:0] encode_high(input logic [N-1:0] vec);
    logic [W-1:0] idx;
    idx = {W{1'b0}};
    for (int i = 0; i < N; i++) begin
      if (vec[i]) begin
        idx = W'(i);
      end else begin
        idx = idx;
      end
    end
    return idx;
  endfunction

  function automatic logic [N-1:0] onehot(input logic [W-1:0] idx);
    logic [N-1:0] v;
    v = {N{1'b0}};
    v[idx] = 1'b1;
    return v;
  endfunction

  // Eligibility, encoding and pending-register update (set wins over ack clear).
  always_comb begin
    eligible_s = pending_r & mask;
    enc_s      = encode_high(eligible_s);
    found_s    = |eligible_s;
    if ((state_r == PRESENT) && ack) begin
      clr_vec_s = onehot(eout_r);
    end else begin
      clr_vec_s = {N{1'b0}};
    end
    pending_next_s = (pending_r & ~clr_vec_s) | (ld ? req : {N{1'b0}});
  end

  // Grant FSM: capture a code in IDLE, freeze it in PRESENT until ack.
  always_comb begin
    state_next_s = state_r;
    eout_next_s  = eout_r;
    valid_next_s = valid_r;
    case (state_r)
      IDLE: begin
        if (found_s) begin
          eout_next_s  = enc_s;
          valid_next_s = 1'b1;
          state_next_s = PRESENT;
        end else begin
          valid_next_s = 1'b0;
        end
      end
      PRESENT: begin
        if (ack) begin
          valid_next_s = 1'b0;
          state_next_s = IDLE;
        end else begin
          valid_next_s = 1'b1;
        end
      end
      default: begin
        valid_next_s = 1'b0;
        state_next_s = IDLE;
      end
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      state_r   <= IDLE;
      eout_r    <= {W{1'b0}};
      valid_r   <= 1'b0;
      pending_r <= {N{1'b0}};
    end else begin
      state_r   <= state_next_s;
      eout_r    <= eout_next_s;
      valid_r   <= valid_next_s;
      pending_r <= pending_next_s;
    end
  end

  assign eout    = eout_r;
  assign valid   = valid_r;
  assign pending = pending_r;

endmodule

// File: tb/tb_priority_encoder_32x5.sv
// Directed, table-driven bench for priority_encoder_32x5 with hand-written
// sequences for reset behaviour and the full 32-deep grant drain.
module tb_priority_encoder_32x5;

  logic        clk;
  logic        clr;
  logic [31:0] req;
  logic        ld;
  logic [31:0] mask;
  logic        ack;
  logic [4:0]  eout;
  logic        valid;
  logic [31:0] pending;

  int n_cmp = 0;
  int n_err = 0;

  priority_encoder_32x5 dut (
    .clk     (clk),
    .clr     (clr),
    .req     (req),
    .ld      (ld),
    .mask    (mask),
    .ack     (ack),
    .eout    (eout),
    .valid   (valid),
    .pending (pending)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] req;
    logic        ld;
    logic [31:0] mask;
    logic        ack;
    logic [4:0]  eout;
    logic        valid;
    logic [31:0] pend;
  } vec_t;

  localparam int NV = 30;
  vec_t tbl [NV];

  function automatic vec_t mk(input logic [31:0] r, input logic l, input logic [31:0] m,
                              input logic a, input logic [4:0] e, input logic v,
                              input logic [31:0] p);
    vec_t t;
    t.req = r; t.ld = l; t.mask = m; t.ack = a;
    t.eout = e; t.valid = v; t.pend = p;
    return t;
  endfunction

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_all(input string nm, input logic [4:0] e, input logic v,
                           input logic [31:0] p);
    check({nm, ".eout"}, {27'd0, eout}, {27'd0, e});
    check({nm, ".valid"}, {31'd0, valid}, {31'd0, v});
    check({nm, ".pending"}, pending, p);
  endtask

  initial begin
    logic [31:0] exp_p;
    // Each row: inputs driven before an edge, outputs expected after it.
    tbl[0]  = mk(32'h00000400, 1'b1, 32'hFFFFFFFF, 1'b0, 5'd0,  1'b0, 32'h00000400);
    tbl[1]  = mk(32'h00000000, 1'b0, 32'hFFFFFFFF, 1'b0, 5'd10, 1'b1, 32'h00000400);
    tbl[2]  = mk(32'h00000000, 1'b0, 32'hFFFFFFFF, 1'b0, 5'd10, 1'b1, 32'h00000400);
    tbl[3]  = mk(32'h00000000, 1'b0, 32'hFFFFFFFF, 1'b1, 5'd10, 1'b0, 32'h00000000);
    tbl[4]  = mk(32'h00000000, 1'b0, 32'hFFFFFFFF, 1'b1, 5'd10, 1'b0, 32'h00000000);
    tbl[5]  = mk(32'h80000001, 1'b1, 32'hFFFFFFFF, 1'b1, 5'd10, 1'b0, 32'h80000001);
    tbl[6]  = mk(32'h00000000, 1'b0, 32'hFFFFFFFF, 1'b1, 5'd31, 1'b1, 32'h80000001);
    tbl[7]  = mk(32'h00000000, 1'b0, 32'hFFFFFFFF, 1'b1, 5'd31, 1'b0, 32'h00000001);
    tbl[8]  = mk(32'h00000000, 1'b0, 32'hFFFFFFFF, 1'b1, 5'd0,  1'b1, 32'h00000001);
    tbl[9]  = mk(32'h00000000, 1'b0, 32'hFFFFFFFF, 1'b1, 5'd0,  1'b0, 32'h00000000);
    tbl[10] = mk(32'h00000000, 1'b0, 32'hFFFFFFFF, 1'b0, 5'd0,  1'b0, 32'h00000000);
    tbl[11] = mk(32'h00000008, 1'b1, 32'hFFFFFFFF, 1'b0, 5'd0,  1'b0, 32'h00000008);
    tbl[12] = mk(32'h00000000, 1'b0, 32'hFFFFFFFF, 1'b0, 5'd3,  1'b1, 32'h00000008);
    tbl[13] = mk(32'h00010000, 1'b1, 32'hFFFFFFFF, 1'b0, 5'd3,  1'b1, 32'h00010008);
    tbl[14] = mk(32'h00000000, 1'b0, 32'h00000000, 1'b0, 5'd3,  1'b1, 32'h00010008);
    tbl[15] = mk(32'h00000000, 1'b0, 32'hFFFFFFFF, 1'b1, 5'd3,  1'b0, 32'h00010000);
    tbl[16] = mk(32'h00000000, 1'b0, 32'hFFFFFFFF, 1'b0, 5'd16, 1'b1, 32'h00010000);
    tbl[17] = mk(32'h00000000, 1'b0, 32'hFFFFFFFF, 1'b1, 5'd16, 1'b0, 32'h00000000);
    tbl[18] = mk(32'h00000030, 1'b1, 32'h00000010, 1'b0, 5'd16, 1'b0, 32'h00000030);
    tbl[19] = mk(32'h00000000, 1'b0, 32'h00000010, 1'b0, 5'd4,  1'b1, 32'h00000030);
    tbl[20] = mk(32'h00000010, 1'b1, 32'h00000010, 1'b1, 5'd4,  1'b0, 32'h00000030);
    tbl[21] = mk(32'h00000000, 1'b0, 32'h00000010, 1'b0, 5'd4,  1'b1, 32'h00000030);
    tbl[22] = mk(32'h00000000, 1'b0, 32'h00000020, 1'b1, 5'd4,  1'b0, 32'h00000020);
    tbl[23] = mk(32'h00000000, 1'b0, 32'h00000020, 1'b0, 5'd5,  1'b1, 32'h00000020);
    tbl[24] = mk(32'h00000000, 1'b0, 32'h00000020, 1'b1, 5'd5,  1'b0, 32'h00000000);
    tbl[25] = mk(32'h000000FF, 1'b1, 32'h00000000, 1'b0, 5'd5,  1'b0, 32'h000000FF);
    tbl[26] = mk(32'h00000000, 1'b0, 32'h00000000, 1'b0, 5'd5,  1'b0, 32'h000000FF);
    tbl[27] = mk(32'h00000100, 1'b1, 32'h00000000, 1'b0, 5'd5,  1'b0, 32'h000001FF);
    tbl[28] = mk(32'h00000000, 1'b0, 32'h00000000, 1'b0, 5'd5,  1'b0, 32'h000001FF);
    tbl[29] = mk(32'h00000000, 1'b0, 32'h00000080, 1'b0, 5'd7,  1'b1, 32'h000001FF);

    // Reset held with all requests loading: nothing may get through.
    clr = 1'b0; req = 32'hFFFFFFFF; ld = 1'b1; mask = 32'hFFFFFFFF; ack = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      check_all($sformatf("reset%0d", i), 5'd0, 1'b0, 32'h00000000);
    end
    clr = 1'b1; req = 32'h0; ld = 1'b0;
    step();
    check_all("post_reset", 5'd0, 1'b0, 32'h00000000);

    for (int i = 0; i < NV; i++) begin
      req = tbl[i].req; ld = tbl[i].ld; mask = tbl[i].mask; ack = tbl[i].ack;
      step();
      check_all($sformatf("row%0d", i), tbl[i].eout, tbl[i].valid, tbl[i].pend);
    end

    // Reset pulse between edges while grant 7 is active.
    mask = 32'hFFFFFFFF; ack = 1'b0; ld = 1'b0; req = 32'h0;
    #2;
    clr = 1'b0;
    #1;
    check_all("midreset", 5'd0, 1'b0, 32'h00000000);
    #1;
    clr = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      check_all($sformatf("after_rst%0d", i), 5'd0, 1'b0, 32'h00000000);
    end
    req = 32'h00000001; ld = 1'b1;
    step();
    check_all("reload", 5'd0, 1'b0, 32'h00000001);
    req = 32'h0; ld = 1'b0;
    step();
    check_all("grant0", 5'd0, 1'b1, 32'h00000001);
    ack = 1'b1;
    step();
    check_all("ack0", 5'd0, 1'b0, 32'h00000000);

    // All 32 lines pending, ack held high: drain 31 down to 0.
    req = 32'hFFFFFFFF; ld = 1'b1;
    step();
    check_all("load_all", 5'd0, 1'b0, 32'hFFFFFFFF);
    req = 32'h0; ld = 1'b0;
    for (int k = 31; k >= 0; k--) begin
      step();
      exp_p = 32'((64'd1 << (k + 1)) - 64'd1);
      check_all($sformatf("drain_g%0d", k), 5'(k), 1'b1, exp_p);
      step();
      exp_p = 32'((64'd1 << k) - 64'd1);
      check_all($sformatf("drain_a%0d", k), 5'(k), 1'b0, exp_p);
    end
    ack = 1'b0;
    step();
    check_all("drain_end", 5'd0, 1'b0, 32'h00000000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
